// File: rtl/player_sprite_render.sv
// Player sprite stage: moves and faces the player once per frame, then turns
// each scan pixel into a sprite ROM address and a registered colour/opaque pair.
module player_sprite_render #(
   parameter int          ADDRESS    = 11,
   parameter int          COLOR_BITS = 24,
   parameter int          SPRITE_W   = 32,
   parameter int          SPRITE_H   = 64,
   parameter int          SCREEN_W   = 640,
   parameter int          SCREEN_H   = 480,
   parameter int          SPEED      = 2,
   parameter logic [23:0] KEY_COLOR  = 24'hFF00FF,
   parameter int          INIT_X     = 304,
   parameter int          INIT_Y     = 400
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  video_on,
   input  logic [9:0]            pix_x,
   input  logic [9:0]            pix_y,
   output logic [ADDRESS-1:0]    rom_addr,
   input  logic [COLOR_BITS-1:0] rom_data,
   output logic [9:0]            pos_x,
   output logic [9:0]            pos_y,
   output logic                  facing_left,
   output logic [COLOR_BITS-1:0] pix_color,
   output logic                  pix_opaque
);

   localparam logic [COLOR_BITS-1:0] KEY   = KEY_COLOR[COLOR_BITS-1:0];
   localparam logic signed [10:0]    MAX_X = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0]    MAX_Y = 11'(SCREEN_H - SPRITE_H);
   localparam logic signed [10:0]    STEP  = 11'(SPEED);

   typedef enum logic {FACE_RIGHT = 1'b0, FACE_LEFT = 1'b1} face_t;

   face_t                 face;
   logic [9:0]            next_x, next_y;
   logic [10:0]           px, py, bx, by, dx, dy, col;
   logic                  hit;
   logic [ADDRESS-1:0]    lin_addr;
   logic                  hit_d1;
   logic                  opaque;

   // Signed 11-bit step-and-clamp keeps moves past either edge from wrapping.
   function automatic logic [9:0] step_clamp(input logic [9:0] cur, input logic dec,
                                             input logic inc, input logic signed [10:0] max_v);
      logic signed [10:0] n;
      n = $signed({1'b0, cur});
      if (dec & ~inc)
         n = n - STEP;
      else if (inc & ~dec)
         n = n + STEP;
      if (n < 0)
         n = '0;
      else if (n > max_v)
         n = max_v;
      return n[9:0];
   endfunction

   assign next_x      = step_clamp(pos_x, btn_left, btn_right, MAX_X);
   assign next_y      = step_clamp(pos_y, btn_up, btn_down, MAX_Y);
   assign facing_left = (face == FACE_LEFT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_x <= 10'(INIT_X);
         pos_y <= 10'(INIT_Y);
         face  <= FACE_RIGHT;
      end else if (frame_tick) begin
         pos_x <= next_x;
         pos_y <= next_y;
         case (face)
            FACE_RIGHT: if (btn_left & ~btn_right) face <= FACE_LEFT;
            FACE_LEFT:  if (btn_right & ~btn_left) face <= FACE_RIGHT;
            default:    face <= FACE_RIGHT;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      px  = {1'b0, pix_x};
      py  = {1'b0, pix_y};
      bx  = {1'b0, pos_x};
      by  = {1'b0, pos_y};
      dx  = px - bx;
      dy  = py - by;
      hit = video_on && (px >= bx) && (px < bx + 11'(SPRITE_W))
                     && (py >= by) && (py < by + 11'(SPRITE_H));
      col = dx;
      if (face == FACE_LEFT)
         col = 11'(SPRITE_W - 1) - dx;
      lin_addr = ADDRESS'(dy) * ADDRESS'(SPRITE_W) + ADDRESS'(col);
   end

   assign opaque = hit_d1 && (rom_data != KEY);

   // NOTE: every pipeline register is reset, so in-flight pixels are dropped
   // and the outputs read 0 until fresh pixels have crossed both stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr   <= '0;
         hit_d1     <= 1'b0;
         pix_color  <= '0;
         pix_opaque <= 1'b0;
      end else begin
         rom_addr   <= hit ? lin_addr : '0;
         hit_d1     <= hit;
         pix_opaque <= opaque;
         pix_color  <= opaque ? rom_data : '0;
      end
   end

endmodule
